// File: rtl/param_rx_fifo_axil_if.sv
// AXI4-Lite slave channel bundle for the parametrised receive FIFO.
interface param_rx_fifo_axil_if;
   logic [3:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [3:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

// File: rtl/param_rx_fifo_axil.sv
// Receive FIFO for a non-stallable sample stream, drained over AXI4-Lite.
// Adds occupancy, threshold irq, sticky overflow/underflow, capture enable and flush.
module param_rx_fifo_axil #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 1024,
   parameter int unsigned ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic                  in_tvalid,
   param_rx_fifo_axil_if.slave   s_axi,
   output logic                  irq
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W-1:0]     wptr;
   logic [ADDR_W-1:0]     rptr;
   logic [CNT_W-1:0]      count;
   logic                  cap_en;
   logic                  irq_en;
   logic [15:0]           threshold;
   logic                  ovf;
   logic                  udf;

   logic        wr_acc;
   logic        rd_acc;
   logic [1:0]  wr_sel;
   logic [1:0]  rd_sel;
   logic        empty;
   logic        full;
   logic        thr_hit;
   logic        flush;
   logic        pop_req;
   logic        pop;
   logic        push_try;
   logic        push;
   logic        ovf_set;
   logic        udf_set;
   logic        ovf_clr;
   logic        udf_clr;
   logic [31:0] rd_word;

   // Handshake decode and push/pop arbitration
   always_comb begin
      wr_acc   = s_axi.s_axi_awready & s_axi.s_axi_awvalid & s_axi.s_axi_wvalid;
      rd_acc   = s_axi.s_axi_arready & s_axi.s_axi_arvalid;
      wr_sel   = s_axi.s_axi_awaddr[3:2];
      rd_sel   = s_axi.s_axi_araddr[3:2];
      empty    = (count == '0);
      full     = (count == DEPTH_CNT);
      thr_hit  = (32'(count) >= {16'd0, threshold});
      flush    = wr_acc & (wr_sel == 2'd3) & s_axi.s_axi_wstrb[0] & s_axi.s_axi_wdata[1];
      ovf_clr  = wr_acc & (wr_sel == 2'd2) & s_axi.s_axi_wstrb[0] & s_axi.s_axi_wdata[2];
      udf_clr  = wr_acc & (wr_sel == 2'd2) & s_axi.s_axi_wstrb[0] & s_axi.s_axi_wdata[3];
      pop_req  = rd_acc & (rd_sel == 2'd0);
      pop      = pop_req & ~empty;
      udf_set  = pop_req & empty;
      push_try = in_tvalid & cap_en;
      // A concurrent pop frees the slot, so a full FIFO still accepts the push
      push     = push_try & (~full | pop) & ~flush;
      ovf_set  = push_try & full & ~pop & ~flush;
   end

   // Register readout, sampled from pre-edge state
   always_comb begin
      rd_word = '0;
      case (rd_sel)
         2'd0: rd_word = empty ? 32'd0 : 32'(mem[rptr]);
         2'd1: rd_word = 32'(count);
         2'd2: rd_word = {27'd0, thr_hit, udf, ovf, full, empty};
         default: rd_word = {threshold, 13'd0, irq_en, 1'b0, cap_en};
      endcase
   end

   // Sample storage, contents need no reset
   always_ff @(posedge ACLK) begin
      if (push) mem[wptr] <= in_tdata;
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         wptr                <= '0;
         rptr                <= '0;
         count               <= '0;
         cap_en              <= 1'b0;
         irq_en              <= 1'b0;
         threshold           <= '0;
         ovf                 <= 1'b0;
         udf                 <= 1'b0;
         irq                 <= 1'b0;
         s_axi.s_axi_awready <= 1'b0;
         s_axi.s_axi_wready  <= 1'b0;
         s_axi.s_axi_bvalid  <= 1'b0;
         s_axi.s_axi_arready <= 1'b0;
         s_axi.s_axi_rvalid  <= 1'b0;
         s_axi.s_axi_rdata   <= '0;
      end else begin
         // Joint address/data accept, one-cycle ready pulse
         s_axi.s_axi_awready <= s_axi.s_axi_awvalid & s_axi.s_axi_wvalid &
                                ~s_axi.s_axi_bvalid & ~s_axi.s_axi_awready;
         s_axi.s_axi_wready  <= s_axi.s_axi_awvalid & s_axi.s_axi_wvalid &
                                ~s_axi.s_axi_bvalid & ~s_axi.s_axi_awready;
         if (wr_acc)
            s_axi.s_axi_bvalid <= 1'b1;
         else if (s_axi.s_axi_bready)
            s_axi.s_axi_bvalid <= 1'b0;

         s_axi.s_axi_arready <= s_axi.s_axi_arvalid & ~s_axi.s_axi_rvalid &
                                ~s_axi.s_axi_arready;
         if (rd_acc) begin
            s_axi.s_axi_rvalid <= 1'b1;
            s_axi.s_axi_rdata  <= rd_word;
         end else if (s_axi.s_axi_rready) begin
            s_axi.s_axi_rvalid <= 1'b0;
         end

         if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
         end else begin
            if (push) wptr <= wptr + ADDR_W'(1);
            if (pop)  rptr <= rptr + ADDR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end

         // Set wins over a same-cycle write-1-to-clear
         ovf <= ovf_set | (ovf & ~ovf_clr);
         udf <= udf_set | (udf & ~udf_clr);

         if (wr_acc && wr_sel == 2'd3) begin
            if (s_axi.s_axi_wstrb[0]) begin
               cap_en <= s_axi.s_axi_wdata[0];
               irq_en <= s_axi.s_axi_wdata[2];
            end
            if (s_axi.s_axi_wstrb[2]) threshold[7:0]  <= s_axi.s_axi_wdata[23:16];
            if (s_axi.s_axi_wstrb[3]) threshold[15:8] <= s_axi.s_axi_wdata[31:24];
         end

         irq <= irq_en & (thr_hit | ovf);
      end
   end

   assign s_axi.s_axi_bresp = 2'b00;
   assign s_axi.s_axi_rresp = 2'b00;

   logic unused_bits;
   assign unused_bits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0],
                          s_axi.s_axi_wdata[15:4], s_axi.s_axi_wstrb[1]};

endmodule

// File: tb/tb_param_rx_fifo_axil.sv
// Directed bench for param_rx_fifo_axil (DEPTH=4) with a queue-based reference model.
module tb_param_rx_fifo_axil;
   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_tdata;
   logic          in_tvalid;
   logic          irq;

   always #5 clk = ~clk;

   param_rx_fifo_axil_if axi();

   param_rx_fifo_axil #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .ACLK     (clk),
      .ARESET   (rst),
      .in_tdata (in_tdata),
      .in_tvalid(in_tvalid),
      .s_axi    (axi),
      .irq      (irq)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- reference model: queue of samples plus flags ----------------
   int unsigned  mq[$];
   bit           m_en, m_ien, m_ovf, m_udf;
   int unsigned  m_thr;
   bit           exp_irq = 1'b0;
   logic [31:0]  exp_rd[$];
   int unsigned  sz;
   bit           m_full, wr_hs, rd_hs, flush_m, pop_req_m, pop_ok_m, ovf_s, udf_s;
   logic [31:0]  rv, wd;
   logic [3:0]   ws;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         exp_rd.delete();
         m_en = 0; m_ien = 0; m_ovf = 0; m_udf = 0; m_thr = 0; exp_irq = 0;
      end else begin
         sz      = mq.size();
         m_full  = (sz == DEPTH);
         exp_irq = m_ien && ((sz >= m_thr) || m_ovf);
         wr_hs   = axi.s_axi_awready && axi.s_axi_awvalid && axi.s_axi_wvalid;
         rd_hs   = axi.s_axi_arready && axi.s_axi_arvalid;
         wd      = axi.s_axi_wdata;
         ws      = axi.s_axi_wstrb;
         flush_m = wr_hs && axi.s_axi_awaddr[3:2] == 2'd3 && ws[0] && wd[1];
         pop_req_m = rd_hs && axi.s_axi_araddr[3:2] == 2'd0;
         pop_ok_m  = pop_req_m && sz > 0;
         udf_s     = pop_req_m && sz == 0;
         ovf_s     = 0;
         if (rd_hs) begin
            case (axi.s_axi_araddr[3:2])
               2'd0: rv = (sz > 0) ? mq[0] : 32'd0;
               2'd1: rv = sz;
               2'd2: rv = {27'd0, 1'(sz >= m_thr), m_udf, m_ovf, m_full, 1'(sz == 0)};
               default: rv = {m_thr[15:0], 13'd0, m_ien, 1'b0, m_en};
            endcase
            exp_rd.push_back(rv);
         end
         if (flush_m) begin
            mq.delete();
         end else begin
            if (pop_ok_m) void'(mq.pop_front());
            if (in_tvalid && m_en) begin
               if (!m_full || pop_ok_m) mq.push_back(in_tdata);
               else ovf_s = 1;
            end
         end
         if (wr_hs && axi.s_axi_awaddr[3:2] == 2'd2 && ws[0]) begin
            if (wd[2]) m_ovf = 0;
            if (wd[3]) m_udf = 0;
         end
         if (ovf_s) m_ovf = 1;
         if (udf_s) m_udf = 1;
         if (wr_hs && axi.s_axi_awaddr[3:2] == 2'd3) begin
            if (ws[0]) begin m_en = wd[0]; m_ien = wd[2]; end
            if (ws[2]) m_thr[7:0]  = wd[23:16];
            if (ws[3]) m_thr[15:8] = wd[31:24];
         end
      end
   end

   // Per-cycle compare of irq and every returned read word against the model
   bit rd_checked = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         check("irq_model", {31'd0, irq}, {31'd0, exp_irq});
         if (axi.s_axi_rvalid && !rd_checked) begin
            rd_checked = 1'b1;
            if (exp_rd.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
            else check("rdata_model", axi.s_axi_rdata, exp_rd.pop_front());
            check("rresp", {30'd0, axi.s_axi_rresp}, 32'd0);
         end
         if (!axi.s_axi_rvalid) rd_checked = 1'b0;
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input bit with_push, input logic [31:0] pdata);
      int n;
      @(negedge clk);
      axi.s_axi_awaddr = addr; axi.s_axi_wdata = data; axi.s_axi_wstrb = strb;
      axi.s_axi_awvalid = 1'b1; axi.s_axi_wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.s_axi_awready && n < 20);
      check("aw_accept", {31'd0, axi.s_axi_awready}, 32'd1);
      check("w_accept", {31'd0, axi.s_axi_wready}, 32'd1);
      if (with_push) begin in_tvalid = 1'b1; in_tdata = pdata; end
      @(posedge clk); #1;
      axi.s_axi_awvalid = 1'b0; axi.s_axi_wvalid = 1'b0; in_tvalid = 1'b0;
      @(negedge clk);
      check("bvalid", {31'd0, axi.s_axi_bvalid}, 32'd1);
      check("bresp", {30'd0, axi.s_axi_bresp}, 32'd0);
   endtask

   task automatic axi_read(input logic [3:0] addr, output logic [31:0] data,
                           input bit with_push, input logic [31:0] pdata);
      int n;
      @(negedge clk);
      axi.s_axi_araddr = addr; axi.s_axi_arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!axi.s_axi_arready && n < 20);
      check("ar_accept", {31'd0, axi.s_axi_arready}, 32'd1);
      if (with_push) begin in_tvalid = 1'b1; in_tdata = pdata; end
      @(posedge clk); #1;
      axi.s_axi_arvalid = 1'b0; in_tvalid = 1'b0;
      @(negedge clk);
      check("rvalid", {31'd0, axi.s_axi_rvalid}, 32'd1);
      data = axi.s_axi_rdata;
   endtask

   task automatic wr(input logic [3:0] addr, input logic [31:0] data);
      axi_write(addr, data, 4'hF, 1'b0, 32'd0);
   endtask

   task automatic rd_expect(input string name, input logic [3:0] addr,
                            input logic [31:0] mask, input logic [31:0] exp);
      logic [31:0] v;
      axi_read(addr, v, 1'b0, 32'd0);
      check(name, v & mask, exp);
   endtask

   task automatic push_burst(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_tvalid = 1'b1; in_tdata = base + 32'(i);
      end
      @(negedge clk);
      in_tvalid = 1'b0;
   endtask

   localparam logic [31:0] ALL = 32'hFFFF_FFFF;

   initial begin
      logic [31:0] v;
      rst = 1'b1; in_tvalid = 1'b0; in_tdata = '0;
      axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0; axi.s_axi_wdata = '0;
      axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0; axi.s_axi_bready = 1'b1;
      axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_awready", {31'd0, axi.s_axi_awready}, 32'd0);
      check("rst_wready",  {31'd0, axi.s_axi_wready},  32'd0);
      check("rst_bvalid",  {31'd0, axi.s_axi_bvalid},  32'd0);
      check("rst_arready", {31'd0, axi.s_axi_arready}, 32'd0);
      check("rst_rvalid",  {31'd0, axi.s_axi_rvalid},  32'd0);
      check("rst_rdata",   axi.s_axi_rdata, 32'd0);
      check("rst_irq",     {31'd0, irq}, 32'd0);
      rst = 1'b0;

      // Registers after reset
      rd_expect("reset_data",   4'h0, ALL, 32'd0);
      rd_expect("reset_count",  4'h4, ALL, 32'd0);
      rd_expect("reset_status", 4'h8, 32'hF, 32'h9);
      rd_expect("reset_ctrl",   4'hC, ALL, 32'd0);

      // Basic in-order capture
      wr(4'h8, 32'h8);
      wr(4'hC, 32'h1);
      push_burst(32'h1, 4);
      rd_expect("basic_count", 4'h4, ALL, 32'd4);
      for (int i = 1; i <= 4; i++) rd_expect("basic_data", 4'h0, ALL, 32'(i));
      rd_expect("basic_empty", 4'h8, 32'h1, 32'h1);

      // Overflow on a full FIFO, then W1C
      push_burst(32'hA, 6);
      rd_expect("ovf_count",  4'h4, ALL, 32'd4);
      rd_expect("ovf_status", 4'h8, 32'hF, 32'h6);
      for (int i = 0; i < 4; i++) rd_expect("ovf_data", 4'h0, ALL, 32'hA + 32'(i));
      wr(4'h8, 32'h4);
      rd_expect("ovf_cleared", 4'h8, 32'hF, 32'h1);

      // Pointer wraparound
      for (int k = 0; k < 5; k++) begin
         push_burst(32'h100 + 32'(3 * k), 3);
         for (int i = 0; i < 3; i++)
            rd_expect("wrap_data", 4'h0, ALL, 32'h100 + 32'(3 * k + i));
      end

      // Threshold interrupt
      wr(4'hC, 32'h0003_0005);
      push_burst(32'h200, 3);
      check("irq_not_yet", {31'd0, irq}, 32'd0);
      @(negedge clk);
      check("irq_rise", {31'd0, irq}, 32'd1);
      rd_expect("irq_pop", 4'h0, ALL, 32'h200);
      check("irq_hold", {31'd0, irq}, 32'd1);
      @(negedge clk);
      check("irq_fall", {31'd0, irq}, 32'd0);

      // Full FIFO with a concurrent pop and push
      wr(4'hC, 32'h1);
      rd_expect("drain0", 4'h0, ALL, 32'h201);
      rd_expect("drain1", 4'h0, ALL, 32'h202);
      push_burst(32'h21, 4);
      axi_read(4'h0, v, 1'b1, 32'h25);
      check("full_pop_data", v, 32'h21);
      rd_expect("full_pop_count", 4'h4, ALL, 32'd4);
      rd_expect("full_pop_no_ovf", 4'h8, 32'h4, 32'h0);

      // Flush with a concurrent push keeps sticky flags
      push_burst(32'h30, 1);
      rd_expect("pre_flush_ovf", 4'h8, 32'h4, 32'h4);
      axi_write(4'hC, 32'h3, 4'hF, 1'b1, 32'h31);
      rd_expect("flush_count",  4'h4, ALL, 32'd0);
      rd_expect("flush_status", 4'h8, 32'hF, 32'h5);
      rd_expect("flush_ctrl",   4'hC, ALL, 32'h1);
      push_burst(32'h40, 1);
      rd_expect("post_flush_data", 4'h0, ALL, 32'h40);

      // Capture disabled ignores samples
      wr(4'hC, 32'h0);
      push_burst(32'h50, 1);
      rd_expect("disabled_count", 4'h4, ALL, 32'd0);

      // Byte strobes gate threshold bytes
      axi_write(4'hC, 32'h0007_0001, 4'h1, 1'b0, 32'd0);
      rd_expect("wstrb_ctrl", 4'hC, ALL, 32'h1);

      // Pop on empty with concurrent push
      wr(4'h8, 32'hC);
      axi_read(4'h0, v, 1'b1, 32'h60);
      check("empty_pop_data", v, 32'd0);
      rd_expect("empty_pop_status", 4'h8, 32'hF, 32'h8);
      rd_expect("empty_pop_next", 4'h0, ALL, 32'h60);

      repeat (3) @(negedge clk);
      check("model_reads_drained", 32'(exp_rd.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
